demux4_reg: RTL and testbench
=============================

Name: demux4_reg

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the pipeline's 4-input select muxes.
- Routes one producer stream to one of four consumer lanes, chosen per word by a 2-bit select.
- Each lane has a single-entry holding register, so backpressure on one lane never corrupts another.
- Sits between a pipeline stage and up to four downstream consumers (e.g. writeback/forwarding targets).

Parameters:
- WIDTH, 32, data width of the input word and of each lane output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all lane holding registers
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the input word this cycle
- in_sel  input  2  destination lane, 0..3
- in_data  input  WIDTH  input word
- out_valid  output  4  bit i = lane i holds a valid word
- out_ready  input  4  bit i = consumer i accepts lane i this cycle
- out_data0  output  WIDTH  lane 0 word
- out_data1  output  WIDTH  lane 1 word
- out_data2  output  WIDTH  lane 2 word
- out_data3  output  WIDTH  lane 3 word

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=4'b0000; out_data0..3=0; all internal state cleared.
- Input handshake:
  - in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]).
  - in_ready is combinational from flush, in_sel, out_valid and out_ready. It is independent of in_valid.
  - A word is accepted when in_valid && in_ready.
- Latency: an accepted word appears on out_dataN with out_valid[N]=1 on the next rising edge, where N=in_sel. There is no combinational path from in_data to any output.
- Per-lane update each edge, in priority order:
  - flush=1: out_valid[i]<=0; data register keeps its value.
  - Else, accept targeting lane i: data_i<=in_data; out_valid[i]<=1. This covers the lane empty case and the lane draining in the same cycle (pass-through, full throughput).
  - Else, out_valid[i] && out_ready[i]: out_valid[i]<=0.
  - Else: hold.
- Lane output rules:
  - out_dataN is stable while out_valid[N]=1 and out_ready[N]=0.
  - out_ready on an empty lane is ignored.
- Lanes not selected by the current accept drain independently in the same cycle. Several lanes may drain simultaneously.
- in_sel and in_data are don't-care when in_valid=0. in_ready still reflects the in_sel value presented.
- Boundaries:
  - Full lane with out_ready low: in_ready=0 for that in_sel only. Other in_sel values are still accepted.
  - flush together with in_valid: in_ready=0, no accept, all lanes empty next cycle.
  - Reset asserted mid-transfer: the word is lost, all lanes empty, and in_ready is computed from cleared state after release.
- Throughput: one word per cycle sustained when the target lane's consumer holds out_ready high.

Optional Feature:
- Macro: DEMUX4_STATS_EN.
- Defined:
  - Adds output port lane_cnt (4 lanes x 8 bits = 32 bits). Byte i is lane i's accept count.
  - Each byte increments by 1 on each accept targeting lane i and saturates at 8'hFF.
  - Cleared by rst_n. Not cleared by flush.
  - Adds input port cnt_clr (1 bit), which synchronously zeroes all counts. cnt_clr wins over a same-cycle increment.
- Not defined: the ports and counters are absent, and the datapath is identical.

Test Plan:
- Reset, then in_valid=1, in_sel=2, in_data=32'hDEADBEEF, out_ready=4'b0000 -> in_ready=1; next cycle out_valid=4'b0100 and out_data2=32'hDEADBEEF; other lanes stay invalid.
- Lane 2 held full with out_ready[2]=0, then present in_sel=2 -> in_ready=0 and out_data2 unchanged. Switch to in_sel=1, in_data=32'h11 -> accepted; next cycle out_valid=4'b0110.
- Lane 3 full, out_ready[3]=1, in_sel=3, in_data=32'h33 on the same cycle -> in_ready=1; next cycle out_valid[3]=1 and out_data3=32'h33 (pass-through, no bubble).
- Stream 8 words with in_sel=0 and out_ready[0]=1 continuously -> 8 consecutive cycles of out_valid[0]=1 with data in order; in_ready never drops.
- All four lanes full, assert flush with in_valid=1 -> in_ready=0; next cycle out_valid=4'b0000; next accept is loaded normally.
- With DEMUX4_STATS_EN: 300 accepts to lane 1 -> lane_cnt[15:8]=8'hFF. Pulse cnt_clr -> lane_cnt=0. Pulse rst_n low mid-stream -> out_valid=0 and lane_cnt=0 immediately.

Source files
------------

// File: rtl/demux4_reg_if.sv
// Handshake bundle for demux4_reg: one producer stream in, four consumer lanes out.
// The master side is the producer plus the consumers; the slave side is the demux.
interface demux4_reg_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_sel;
   logic [WIDTH-1:0] in_data;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [WIDTH-1:0] out_data0;
   logic [WIDTH-1:0] out_data1;
   logic [WIDTH-1:0] out_data2;
   logic [WIDTH-1:0] out_data3;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
   );
endinterface

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demux with a single-entry holding register per lane.
// Optional per-lane saturating accept counters are enabled by defining DEMUX4_STATS_EN.
module demux4_reg #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
`ifdef DEMUX4_STATS_EN
   input  logic         cnt_clr,
   output logic [31:0]  lane_cnt,
`endif
   demux4_reg_if.slave  bus
);
   logic [3:0]            valid_r;
   logic [3:0][WIDTH-1:0] data_r;
   logic                  in_ready_s;
   logic                  accept_s;
   logic [3:0]            load_s;
   logic [3:0]            drain_s;

   // Accept decode: a lane can take a new word when empty or draining this cycle.
   always_comb begin
      in_ready_s = 1'b0;
      accept_s   = 1'b0;
      load_s     = 4'b0000;
      drain_s    = 4'b0000;
      if (flush) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = !valid_r[bus.in_sel] || bus.out_ready[bus.in_sel];
      end
      accept_s = bus.in_valid && in_ready_s;
      for (int i = 0; i < 4; i++) begin
         load_s[i]  = accept_s && (bus.in_sel == 2'(i));
         drain_s[i] = valid_r[i] && bus.out_ready[i];
      end
   end

   // Lane valid flags: flush first, then load, then drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 4'b0000;
      end else if (flush) begin
         valid_r <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load_s[i]) begin
               valid_r[i] <= 1'b1;
            end else if (drain_s[i]) begin
               valid_r[i] <= 1'b0;
            end else begin
               valid_r[i] <= valid_r[i];
            end
         end
      end
   end

   // Lane data registers only change on a load, so a stalled lane keeps its word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load_s[i]) begin
               data_r[i] <= bus.in_data;
            end else begin
               data_r[i] <= data_r[i];
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = valid_r;
   assign bus.out_data0 = data_r[0];
   assign bus.out_data1 = data_r[1];
   assign bus.out_data2 = data_r[2];
   assign bus.out_data3 = data_r[3];

`ifdef DEMUX4_STATS_EN
   logic [3:0][7:0] cnt_r;

   // Saturating per-lane accept counters; survive flush, clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (cnt_clr) begin
         cnt_r <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load_s[i] && (cnt_r[i] != 8'hFF)) begin
               cnt_r[i] <= cnt_r[i] + 8'd1;
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
      end
   end

   assign lane_cnt = cnt_r;
`endif
endmodule

// File: tb/tb_demux4_reg.sv
// Scoreboard bench for demux4_reg: stimulus pushes expected lane words, a monitor
// pops and compares them whenever a lane handshake (out_valid & out_ready) is seen.
module tb_demux4_reg;
   logic clk;
   logic rst_n;
   logic flush;
   logic cnt_clr;
   int   pass_cnt;
   int   total_cnt;

   logic [31:0] q [4][$];
   logic [31:0] od [4];
   logic [7:0]  cnt_model [4];

   demux4_reg_if #(.WIDTH(32)) bus ();

`ifdef DEMUX4_STATS_EN
   logic [31:0] lane_cnt;
   demux4_reg #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .cnt_clr  (cnt_clr),
      .lane_cnt (lane_cnt),
      .bus      (bus)
   );
`else
   demux4_reg #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      od[0] = bus.out_data0;
      od[1] = bus.out_data1;
      od[2] = bus.out_data2;
      od[3] = bus.out_data3;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: each lane handshake consumes the oldest expected word of that lane.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.out_valid[i] && bus.out_ready[i]) begin
               if (q[i].size() == 0) begin
                  chk($sformatf("unexpected_lane%0d", i), od[i], 32'hxxxxxxxx);
               end else begin
                  chk($sformatf("lane%0d_data", i), od[i], q[i].pop_front());
               end
            end
         end
      end
   end

   task automatic clear_queues();
      for (int i = 0; i < 4; i++) q[i].delete();
   endtask

   // One clock of stimulus plus in_ready / out_valid checks sampled at the falling edge.
   task automatic cyc(input logic v, input logic [1:0] s, input logic [31:0] d,
                      input logic [3:0] r, input logic f, input logic clr,
                      input logic exp_rdy, input logic [3:0] exp_ov, input string nm);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_data   = d;
      bus.out_ready = r;
      flush         = f;
      cnt_clr       = clr;
      @(negedge clk);
      chk({nm, "_in_ready"}, {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      chk({nm, "_out_valid"}, {28'd0, bus.out_valid}, {28'd0, exp_ov});
      if (v && exp_rdy) q[s].push_back(d);
      if (clr) begin
         for (int i = 0; i < 4; i++) cnt_model[i] = 8'h00;
      end else if (v && exp_rdy && cnt_model[s] != 8'hFF) begin
         cnt_model[s] = cnt_model[s] + 8'd1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pass_cnt      = 0;
      total_cnt     = 0;
      rst_n         = 1'b0;
      flush         = 1'b0;
      cnt_clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sel    = 2'd0;
      bus.in_data   = 32'd0;
      bus.out_ready = 4'b0000;
      for (int i = 0; i < 4; i++) cnt_model[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_out_valid", {28'd0, bus.out_valid}, 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("reset_data%0d", i), od[i], 32'd0);
      rst_n = 1'b1;

      // Single word to lane 2, then lane 2 held full while other lanes still load.
      cyc(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, "c1_load2");
      cyc(1'b1, 2'd2, 32'h00000BAD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, "c2_full2");
      chk("c2_hold_data2", od[2], 32'hDEADBEEF);
      cyc(1'b1, 2'd1, 32'h00000011, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100, "c3_load1");
      cyc(1'b1, 2'd3, 32'h00000030, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0110, "c4_load3");
      chk("c4_hold_data2", od[2], 32'hDEADBEEF);
      // Pass-through: lane 3 drains and reloads in the same cycle.
      cyc(1'b1, 2'd3, 32'h00000033, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1110, "c5_pass3");
      cyc(1'b1, 2'd0, 32'h000000A0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1110, "c6_load0");
      chk("c6_data3", od[3], 32'h00000033);
      // Flush with a pending word: rejected, all lanes empty afterwards.
      cyc(1'b1, 2'd0, 32'h000000FF, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1111, "c7_flush");
      clear_queues();
      cyc(1'b0, 2'd0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, "c8_empty");
      cyc(1'b1, 2'd1, 32'h00000055, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, "c9_reload1");
      cyc(1'b0, 2'd1, 32'h00000000, 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010, "c10_drain1");

      // Sustained stream into lane 0 with its consumer always ready.
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 2'd0, 32'h00000100 + 32'(k), 4'b0001, 1'b0, 1'b0, 1'b1,
             (k == 0) ? 4'b0000 : 4'b0001, $sformatf("stream%0d", k));
      end
      cyc(1'b0, 2'd0, 32'h00000000, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, "stream_tail");
      cyc(1'b0, 2'd0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, "stream_idle");

`ifdef DEMUX4_STATS_EN
      // Saturation on lane 1, then clear overriding a same-cycle increment.
      for (int k = 0; k < 300; k++) begin
         cyc(1'b1, 2'd1, 32'h00001000 + 32'(k), 4'b0010, 1'b0, 1'b0, 1'b1,
             (k == 0) ? 4'b0000 : 4'b0010, "sat1");
      end
      cyc(1'b0, 2'd1, 32'h00000000, 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010, "sat_tail");
      chk("cnt_lane1_sat", {24'd0, lane_cnt[15:8]}, 32'h000000FF);
      chk("cnt_all", lane_cnt, {cnt_model[3], cnt_model[2], cnt_model[1], cnt_model[0]});
      cyc(1'b1, 2'd3, 32'h0000003C, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, "cnt_clr");
      cyc(1'b0, 2'd3, 32'h00000000, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, "cnt_after_clr");
      chk("cnt_cleared", lane_cnt, 32'd0);
      cyc(1'b1, 2'd2, 32'h00000022, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, "cnt_restart");
      cyc(1'b0, 2'd2, 32'h00000000, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, "cnt_restart_drain");
      chk("cnt_restart_val", lane_cnt,
          {cnt_model[3], cnt_model[2], cnt_model[1], cnt_model[0]});
`endif

      // Reset asserted while lane 2 holds a word and another is being offered.
      cyc(1'b1, 2'd2, 32'h00000077, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, "rst_load2");
      cyc(1'b1, 2'd0, 32'h00000099, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100, "rst_offer0");
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", {28'd0, bus.out_valid}, 32'd0);
      chk("rst_mid_data2", od[2], 32'd0);
`ifdef DEMUX4_STATS_EN
      chk("rst_mid_cnt", lane_cnt, 32'd0);
`endif
      clear_queues();
      for (int i = 0; i < 4; i++) cnt_model[i] = 8'h00;
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 2'd2, 32'h00000088, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, "post_rst_load");
      cyc(1'b0, 2'd2, 32'h00000000, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, "post_rst_drain");
      cyc(1'b0, 2'd0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, "post_rst_idle");

      for (int i = 0; i < 4; i++) begin
         chk($sformatf("queue%0d_empty", i), 32'(q[i].size()), 32'd0);
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
